// File: rtl/gmii_rx_stream_gen.sv
// AXI-stream to GMII/MII receive-side serializer: preamble/SFD insertion,
// inter-frame gap and a per-symbol clock enable at 10/100/1000 Mb/s.
module gmii_rx_stream_gen #(
    parameter int MIN_IFG = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_clk_en,
    output logic       mii_select,
    output logic       busy,
    output logic       underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_IFG,
        S_DROP
    } state_t;

    localparam logic [8:0] IFG_LAST_GMII = 9'(MIN_IFG - 1);
    localparam logic [8:0] IFG_LAST_MII  = 9'(2 * MIN_IFG - 1);

    state_t     state, state_n;
    logic [5:0] presc, presc_n;
    logic       spd_mii, spd_mii_n;
    logic       spd_ten, spd_ten_n;
    logic [3:0] sym, sym_n;
    logic       nib, nib_n;
    logic [7:0] dat_q, dat_n;
    logic       err_q, err_n;
    logic       last_q, last_n;
    logic [8:0] ifg_q, ifg_n;
    logic       err_sym, err_sym_n;

    logic       ce, ce_n, fetch, start, uf;
    logic [3:0] pre_last, pre_last_n;
    logic [8:0] ifg_last;
    logic [7:0] rxd_d;
    logic       dv_d, er_d, tready_d;

    function automatic logic [5:0] presc_max(input logic mii, input logic ten);
        return ten ? 6'd49 : (mii ? 6'd4 : 6'd0);
    endfunction

    assign ce       = (presc == presc_max(spd_mii, spd_ten));
    assign pre_last = spd_mii ? 4'd15 : 4'd7;
    assign ifg_last = spd_mii ? IFG_LAST_MII : IFG_LAST_GMII;
    // The registered tready already encodes "ce and next symbol starts a data byte".
    assign fetch    = s_axis_tready && (state == S_PREAMBLE || state == S_DATA);

    // NOTE: every sequential register uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            presc         <= '0;
            spd_mii       <= 1'b0;
            spd_ten       <= 1'b0;
            sym           <= '0;
            nib           <= 1'b0;
            dat_q         <= '0;
            err_q         <= 1'b0;
            last_q        <= 1'b0;
            ifg_q         <= '0;
            err_sym       <= 1'b0;
            s_axis_tready <= 1'b0;
            gmii_rxd      <= '0;
            gmii_rx_dv    <= 1'b0;
            gmii_rx_er    <= 1'b0;
            gmii_clk_en   <= 1'b0;
            mii_select    <= 1'b0;
            busy          <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            state         <= state_n;
            presc         <= presc_n;
            spd_mii       <= spd_mii_n;
            spd_ten       <= spd_ten_n;
            sym           <= sym_n;
            nib           <= nib_n;
            dat_q         <= dat_n;
            err_q         <= err_n;
            last_q        <= last_n;
            ifg_q         <= ifg_n;
            err_sym       <= err_sym_n;
            s_axis_tready <= tready_d;
            gmii_rxd      <= rxd_d;
            gmii_rx_dv    <= dv_d;
            gmii_rx_er    <= er_d;
            gmii_clk_en   <= ce;
            mii_select    <= spd_mii_n;
            busy          <= (state_n != S_IDLE);
            underflow     <= uf;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        state_n   = state;
        presc_n   = ce ? 6'd0 : presc + 6'd1;
        spd_mii_n = spd_mii;
        spd_ten_n = spd_ten;
        sym_n     = sym;
        nib_n     = nib;
        dat_n     = dat_q;
        err_n     = err_q;
        last_n    = last_q;
        ifg_n     = ifg_q;
        err_sym_n = ce ? 1'b0 : err_sym;
        uf        = 1'b0;
        start     = 1'b0;
        if (fetch) begin
            if (s_axis_tvalid) begin
                state_n = S_DATA;
                dat_n   = s_axis_tdata;
                err_n   = s_axis_tuser;
                last_n  = s_axis_tlast;
                nib_n   = 1'b0;
            end else begin
                state_n   = S_DROP;
                err_sym_n = 1'b1;
                uf        = 1'b1;
            end
        end else begin
            unique case (state)
                S_IDLE:     start = ce && s_axis_tvalid;
                S_PREAMBLE: if (ce) sym_n = sym + 4'd1;
                S_DATA: begin
                    if (ce) begin
                        if (spd_mii && !nib) begin
                            nib_n = 1'b1;
                        end else begin
                            state_n = S_IFG;
                            ifg_n   = '0;
                        end
                    end
                end
                S_IFG: begin
                    if (ce) begin
                        if (ifg_q != ifg_last)   ifg_n   = ifg_q + 9'd1;
                        else if (s_axis_tvalid) start   = 1'b1;
                        else                     state_n = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_n = S_IFG;
                        ifg_n   = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        // Speed is only sampled when a new frame begins; 11 behaves as 1000M.
        if (start) begin
            state_n   = S_PREAMBLE;
            sym_n     = '0;
            presc_n   = '0;
            spd_mii_n = (speed == 2'b00) || (speed == 2'b01);
            spd_ten_n = (speed == 2'b00);
        end
    end

    // Output values are decoded from the next state so that the pins come straight from flops.
    always_comb begin
        rxd_d      = '0;
        dv_d       = 1'b0;
        er_d       = 1'b0;
        pre_last_n = spd_mii_n ? 4'd15 : 4'd7;
        ce_n       = (presc_n == presc_max(spd_mii_n, spd_ten_n));
        unique case (state_n)
            S_PREAMBLE: begin
                dv_d = 1'b1;
                if (sym_n == pre_last_n) rxd_d = spd_mii_n ? 8'h0D : 8'hD5;
                else                     rxd_d = spd_mii_n ? 8'h05 : 8'h55;
            end
            S_DATA: begin
                dv_d  = 1'b1;
                er_d  = err_n;
                rxd_d = !spd_mii_n ? dat_n : {4'h0, (nib_n ? dat_n[7:4] : dat_n[3:0])};
            end
            default: begin
                dv_d = err_sym_n;
                er_d = err_sym_n;
            end
        endcase
        tready_d = (state_n == S_DROP) ||
                   (ce_n && ((state_n == S_PREAMBLE && sym_n == pre_last_n) ||
                             (state_n == S_DATA && (!spd_mii_n || nib_n) && !last_n)));
    end

endmodule

// File: tb/tb_gmii_rx_stream_gen.sv
// Scoreboard bench for gmii_rx_stream_gen: expected symbols are queued as frames
// are offered and popped on every gmii_clk_en that carries dv or er.
module tb_gmii_rx_stream_gen;

    typedef logic [7:0] bytes_t[$];
    typedef struct packed {
        logic [7:0] rxd;
        logic       er;
    } sym_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed = 2'b10;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tuser = 1'b0;
    logic       s_axis_tready;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv, gmii_rx_er, gmii_clk_en, mii_select, busy, underflow;

    sym_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_ce_cyc = 0;
    int   exp_period = 1;
    logic prev_dv = 1'b0;
    int   dv_cycles = 0;
    int   tready_cycles = 0;
    int   uf_pulses = 0;

    gmii_rx_stream_gen #(.MIN_IFG(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .speed         (speed),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .gmii_clk_en   (gmii_clk_en),
        .mii_select    (mii_select),
        .busy          (busy),
        .underflow     (underflow)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: symbol scoreboard, symbol spacing and event counters.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_dv = 1'b0;
        end else begin
            if (gmii_rx_dv)    dv_cycles++;
            if (s_axis_tready) tready_cycles++;
            if (underflow)     uf_pulses++;
            if (gmii_clk_en) begin
                if (gmii_rx_dv && prev_dv) check("sym_period", cyc - last_ce_cyc, exp_period);
                if (gmii_rx_dv || gmii_rx_er) begin
                    check("sym_expected", int'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        sym_t e;
                        e = sb.pop_front();
                        check("rxd", int'(gmii_rxd), int'(e.rxd));
                        check("rx_er", int'(gmii_rx_er), int'(e.er));
                    end
                end
                last_ce_cyc = cyc;
                prev_dv     = gmii_rx_dv;
            end
        end
    end

    // Queue the symbols a frame should produce; bytes from n_keep on are lost to an underflow.
    task automatic push_frame(input bytes_t data, input int user_idx, input int n_keep, input logic mii);
        if (mii) begin
            for (int i = 0; i < 15; i++) sb.push_back('{rxd: 8'h05, er: 1'b0});
            sb.push_back('{rxd: 8'h0D, er: 1'b0});
        end else begin
            for (int i = 0; i < 7; i++) sb.push_back('{rxd: 8'h55, er: 1'b0});
            sb.push_back('{rxd: 8'hD5, er: 1'b0});
        end
        for (int i = 0; i < n_keep; i++) begin
            if (mii) begin
                sb.push_back('{rxd: {4'h0, data[i][3:0]}, er: (i == user_idx)});
                sb.push_back('{rxd: {4'h0, data[i][7:4]}, er: (i == user_idx)});
            end else begin
                sb.push_back('{rxd: data[i], er: (i == user_idx)});
            end
        end
        if (n_keep < data.size()) sb.push_back('{rxd: 8'h00, er: 1'b1});
    endtask

    task automatic send_frame(input bytes_t data, input int user_idx, input int gap_after, input int gap_len);
        for (int i = 0; i < data.size(); i++) begin
            int n;
            if (rst) break;
            if (i == gap_after) begin
                s_axis_tvalid = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            s_axis_tdata  = data[i];
            s_axis_tlast  = (i == data.size() - 1);
            s_axis_tuser  = (i == user_idx);
            s_axis_tvalid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_axis_tready && !rst && n < 5000);
            if (rst) break;
            check("tready_timeout", int'(s_axis_tready), 1);
            if (!s_axis_tready) break;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(busy), 0);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t frame;
        int     dv0, tr0, uf0, n;

        repeat (3) @(negedge clk);
        check("rst_tready", int'(s_axis_tready), 0);
        check("rst_rxd", int'(gmii_rxd), 0);
        check("rst_dv", int'(gmii_rx_dv), 0);
        check("rst_er", int'(gmii_rx_er), 0);
        check("rst_clk_en", int'(gmii_clk_en), 0);
        check("rst_mii_select", int'(mii_select), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_underflow", int'(underflow), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 1000M, 64-byte counting frame.
        frame = {};
        for (int i = 0; i < 64; i++) frame.push_back(8'(i));
        exp_period = 1;
        dv0 = dv_cycles;
        tr0 = tready_cycles;
        push_frame(frame, -1, 64, 1'b0);
        send_frame(frame, -1, -1, 0);
        n = 0;
        while (gmii_rx_dv && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("t1_dv_fall", int'(gmii_rx_dv), 0);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("t1_busy_tail", n, 12);
        check("t1_dv_cycles", dv_cycles - dv0, 72);
        check("t1_tready_pulses", tready_cycles - tr0, 64);
        check("t1_sb_drained", sb.size(), 0);

        // 100M, two-byte frame.
        speed      = 2'b01;
        exp_period = 5;
        frame      = {8'hA1, 8'h2B};
        push_frame(frame, -1, 2, 1'b1);
        send_frame(frame, -1, -1, 0);
        check("t2_mii_select", int'(mii_select), 1);
        wait_idle("t2_idle");
        check("t2_sb_drained", sb.size(), 0);

        // 1000M, source stalls after three bytes of ten.
        speed      = 2'b10;
        exp_period = 1;
        uf0        = uf_pulses;
        frame      = {};
        for (int i = 0; i < 10; i++) frame.push_back(8'(8'h10 + i));
        push_frame(frame, -1, 3, 1'b0);
        send_frame(frame, -1, 3, 6);
        wait_idle("t3_idle");
        check("t3_underflow_pulses", uf_pulses - uf0, 1);
        check("t3_dv_after", int'(gmii_rx_dv), 0);
        check("t3_sb_drained", sb.size(), 0);

        // Speed changed mid-frame: this frame stays at 1000M, the next one runs at 10M.
        frame = {};
        for (int i = 0; i < 16; i++) frame.push_back(8'(8'h80 + i));
        push_frame(frame, -1, 16, 1'b0);
        fork
            send_frame(frame, -1, -1, 0);
            begin
                repeat (12) @(posedge clk);
                #1 speed = 2'b00;
            end
        join
        check("t5_mii_select_old", int'(mii_select), 0);
        wait_idle("t5_idle_a");
        check("t5_sb_drained_a", sb.size(), 0);
        exp_period = 50;
        frame = {8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'hE7, 8'h7E, 8'h01, 8'hF0};
        push_frame(frame, 4, 8, 1'b1);
        send_frame(frame, 4, -1, 0);
        check("t5_mii_select_new", int'(mii_select), 1);
        wait_idle("t5_idle_b");
        check("t5_sb_drained_b", sb.size(), 0);

        // Reset in the middle of a 100M frame, then a fresh 1000M frame.
        speed      = 2'b01;
        exp_period = 5;
        frame      = {};
        for (int i = 0; i < 20; i++) frame.push_back(8'(8'hC0 + i));
        push_frame(frame, -1, 20, 1'b1);
        fork
            send_frame(frame, -1, -1, 0);
            begin
                repeat (150) @(posedge clk);
                @(negedge clk);
                #1 rst = 1'b1;
                #1;
                check("t6_rst_dv", int'(gmii_rx_dv), 0);
                check("t6_rst_rxd", int'(gmii_rxd), 0);
                check("t6_rst_er", int'(gmii_rx_er), 0);
                check("t6_rst_tready", int'(s_axis_tready), 0);
                check("t6_rst_busy", int'(busy), 0);
                check("t6_rst_mii_select", int'(mii_select), 0);
                sb.delete();
            end
        join
        repeat (3) @(posedge clk);
        speed = 2'b10;
        @(negedge clk);
        rst        = 1'b0;
        exp_period = 1;
        @(posedge clk);
        #1;
        frame = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        push_frame(frame, -1, 4, 1'b0);
        send_frame(frame, -1, -1, 0);
        check("t6_mii_select_after", int'(mii_select), 0);
        wait_idle("t6_idle");
        check("t6_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
